shift_tx_serializer: RTL and testbench
======================================

# shift_tx_serializer

Parallel-in, serial-out transmitter feeding a serial shift chain. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register. It streams each word one bit per enabled clock, with a valid flag and a frame marker, into a downstream serial-in shift register. Words issue back-to-back with no idle bit between them.

## Interface
- WIDTH, 576: word length in bits; must be at least 2.
- MSB_FIRST, 1: 1 sends in_data[WIDTH-1] first, which fills a shift-left chain so the first bit lands at the top; 0 sends in_data[0] first.
- IDLE_LEVEL, 0: value driven on shift_out when no word is being sent.

- clk  input  1  sole clock; all state updates on its rising edge.
- clr  input  1  reset, synchronous, active-high.
- in_data  input  WIDTH  parallel word to send.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  holding register can accept a word.
- shift_en  input  1  advance the serial stream by one bit at this edge.
- shift_out  output  1  current serial bit.
- shift_valid  output  1  shift_out carries a data bit.
- frame_start  output  1  shift_out carries the first bit of a word.
- busy  output  1  a word is being shifted or held.

## Operation
- State: IDLE or SHIFT. Internal registers:
  - sreg (WIDTH bits)
  - cnt ($clog2(WIDTH) bits, bits remaining after the current one)
  - hold_data (WIDTH bits)
  - hold_full (1 bit)
- Accept:
  - in_ready = !hold_full && !clr.
  - When in_valid && in_ready at an edge, hold_data <= in_data and hold_full <= 1.
- Load from IDLE: if hold_full, then at the next edge:
  - state <= SHIFT, sreg <= hold_data, cnt <= WIDTH-1, hold_full <= 0.
- SHIFT, shift_en=0: everything holds; the current bit stays on shift_out.
- SHIFT, shift_en=1, cnt>0: sreg shifts one place toward the output end and cnt decrements. The vacated bit is filled with 0.
- SHIFT, shift_en=1, cnt==0:
  - If hold_full, reload as in "Load from IDLE", staying in SHIFT with no gap.
  - Otherwise go to IDLE.
- Outputs:
  - shift_out = (state==SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_LEVEL.
  - shift_valid = (state==SHIFT).
  - frame_start = (state==SHIFT && cnt==WIDTH-1).
  - busy = (state==SHIFT) || hold_full.
- Simultaneous events:
  - A reload at cnt==0 and an accept of a new word can happen at the same edge only if hold_full was 0. In that case the accept fills the empty holding register and no reload occurs.
  - A reload frees the holding register; in_ready rises in the cycle after the reload edge.
- A consumer samples shift_out whenever shift_valid && shift_en. It uses the same shift_en to advance its own chain.

## Timing
- Reset (clr high at an edge):
  - state=IDLE, hold_full=0, cnt=0, sreg=0.
  - Outputs: shift_out=IDLE_LEVEL, shift_valid=0, frame_start=0, busy=0.
  - in_ready is 0 while clr is high and 1 in the first cycle after clr falls.
- Reset mid-operation: the in-flight word and any held word are discarded. There is no partial continuation; the next word starts at its bit 0.
- Latency:
  - Word accepted at edge N.
  - First bit (shift_valid=1, frame_start=1) visible after edge N+1, if the block was IDLE.
- Word duration: exactly WIDTH enabled edges. With shift_en held at 1, a word occupies WIDTH cycles.
- Throughput: a continuous shift_en=1 with a new word offered every WIDTH cycles produces an unbroken stream. shift_valid never drops between words.
- shift_en while IDLE has no effect.

## Test plan
- Reset: drive clr=1 for 2 cycles with in_valid=1 and in_data=8'hFF (WIDTH=8).
  - Required: no accept; in_ready=0; shift_valid=0; shift_out=0.
  - The cycle after clr falls: in_ready=1, busy=0.
- Single word, WIDTH=8, MSB_FIRST=1, in_data=8'hA5, shift_en=1 constantly.
  - Required: shift_out=1,0,1,0,0,1,0,1 over 8 consecutive cycles starting edge N+1.
  - frame_start=1 on the first bit only; IDLE afterwards with shift_out=0.
- Back-to-back words 8'hA5 then 8'h3C, second offered while the first is shifting, shift_en=1.
  - Required: 16 contiguous valid bits 10100101 00111100 with no gap.
  - frame_start at bit 0 and bit 8.
- Stalling: 8'hA5 with shift_en alternating 1,0.
  - Required: each bit held for 2 cycles; word completes in 16 cycles; bit sequence unchanged.
- LSB-first: MSB_FIRST=0, in_data=8'h01.
  - Required: shift_out=1 then seven 0s.
- Reset mid-word: clr=1 for one cycle after 3 bits of 8'hA5, with 8'h3C held.
  - Required: next cycle shift_valid=0, busy=0; 8'h3C is never sent.
  - A subsequently accepted 8'hFF sends 8 ones, with frame_start on the first.

Source files
------------

// File: rtl/shift_tx_serializer_if.sv
// shift_tx_serializer_if: word handshake and serial stream bundle.
//   in_data/in_valid/in_ready : parallel word handshake into the holding register
//   shift_en                  : advance the serial stream by one bit
//   shift_out/shift_valid     : serial bit and its qualifier
//   frame_start               : first bit of a word is on shift_out
//   busy                      : a word is being shifted or held
// master = word producer / shift-chain consumer, slave = serializer.
interface shift_tx_serializer_if #(
   parameter int unsigned WIDTH = 576
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             shift_en;
   logic             shift_out;
   logic             shift_valid;
   logic             frame_start;
   logic             busy;

   modport master (
      output in_data, in_valid, shift_en,
      input  in_ready, shift_out, shift_valid, frame_start, busy
   );

   modport slave (
      input  in_data, in_valid, shift_en,
      output in_ready, shift_out, shift_valid, frame_start, busy
   );
endinterface

// File: rtl/shift_tx_serializer.sv
// shift_tx_serializer: parallel-in, serial-out transmitter for a serial shift chain.
// Accepts WIDTH-bit words into a one-deep holding register and streams them one
// bit per enabled clock, back-to-back with no idle bit between words.
// Ports:
//   clk  : sole clock, rising edge
//   clr  : synchronous active-high reset
//   bus  : shift_tx_serializer_if.slave (handshake + serial stream signals)
// Parameters:
//   WIDTH      : word length in bits (>= 2)
//   MSB_FIRST  : 1 sends in_data[WIDTH-1] first, 0 sends in_data[0] first
//   IDLE_LEVEL : shift_out level while no word is being sent
module shift_tx_serializer #(
   parameter int unsigned WIDTH      = 576,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input logic                 clk,
   input logic                 clr,
   shift_tx_serializer_if.slave bus
);

   localparam int unsigned     CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_next;
   logic [WIDTH-1:0] hold_data;
   logic [CW-1:0]    cnt;
   logic             hold_full;
   logic             frame_q;
   logic             accept;

   // Holding register refuses words while in reset.
   assign bus.in_ready = !hold_full && !clr;
   assign accept       = bus.in_valid && bus.in_ready;

   // Move one place toward the output end, filling the vacated bit with 0.
   always_comb begin
      sreg_next = '0;
      if (MSB_FIRST)
         sreg_next = {sreg[WIDTH-2:0], 1'b0};
      else
         sreg_next = {1'b0, sreg[WIDTH-1:1]};
   end

   // frame_q mirrors (state==SHIFT && cnt==WIDTH-1) as a register: set on
   // every load, cleared by the first enabled shift or on return to IDLE.
   // A load never coincides with an accept: a load needs hold_full=1, which
   // forces in_ready low.
   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= IDLE;
         sreg      <= '0;
         cnt       <= '0;
         hold_data <= '0;
         hold_full <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         if (accept) begin
            hold_data <= bus.in_data;
            hold_full <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (hold_full) begin
                  state     <= SHIFT;
                  sreg      <= hold_data;
                  cnt       <= CNT_LAST;
                  hold_full <= 1'b0;
                  frame_q   <= 1'b1;
               end
            end
            SHIFT: begin
               if (bus.shift_en) begin
                  frame_q <= 1'b0;
                  if (cnt != '0) begin
                     sreg <= sreg_next;
                     cnt  <= cnt - CW'(1);
                  end else if (hold_full) begin
                     // Seamless reload: next word's first bit follows directly.
                     sreg      <= hold_data;
                     cnt       <= CNT_LAST;
                     hold_full <= 1'b0;
                     frame_q   <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.shift_out   = (state == SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0])
                                             : IDLE_LEVEL;
   assign bus.shift_valid = (state == SHIFT);
   assign bus.frame_start = frame_q;
   assign bus.busy        = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_shift_tx_serializer.sv
module tb_shift_tx_serializer;

   logic clk;
   logic clr;
   int   checks;
   int   passed;

   shift_tx_serializer_if #(.WIDTH(8)) ifm ();
   shift_tx_serializer_if #(.WIDTH(8)) ifl ();

   shift_tx_serializer #(
      .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
   ) dut_msb (
      .clk(clk), .clr(clr), .bus(ifm.slave)
   );

   shift_tx_serializer #(
      .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
   ) dut_lsb (
      .clk(clk), .clr(clr), .bus(ifl.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All sampling and driving happens at the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      clr          = 1'b1;
      ifm.in_valid = 1'b1;
      ifm.in_data  = 8'hFF;
      ifm.shift_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (ifm.in_ready !== 1'b0) $display("FAIL reset_in_ready[%0d] got %b want 0", i, ifm.in_ready);
         else passed++;
         checks++;
         if (ifm.shift_valid !== 1'b0) $display("FAIL reset_shift_valid[%0d] got %b want 0", i, ifm.shift_valid);
         else passed++;
         checks++;
         if (ifm.shift_out !== 1'b0) $display("FAIL reset_shift_out[%0d] got %b want 0", i, ifm.shift_out);
         else passed++;
         checks++;
         if (ifm.busy !== 1'b0) $display("FAIL reset_busy[%0d] got %b want 0", i, ifm.busy);
         else passed++;
      end
      clr          = 1'b0;
      ifm.in_valid = 1'b0;
      #1;
      checks++;
      if (ifm.in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b want 1", ifm.in_ready);
      else passed++;
      tick();
      checks++;
      if (ifm.busy !== 1'b0) $display("FAIL reset_release_busy got %b want 0", ifm.busy);
      else passed++;
      checks++;
      if (ifm.frame_start !== 1'b0) $display("FAIL reset_release_frame got %b want 0", ifm.frame_start);
      else passed++;
   endtask

   task automatic test_single_msb();
      logic [7:0] exp;
      exp = 8'hA5;
      ifm.shift_en = 1'b1;
      tick();
      checks++;
      if (ifm.in_ready !== 1'b1) $display("FAIL single_in_ready got %b want 1", ifm.in_ready);
      else passed++;
      ifm.in_data  = 8'hA5;
      ifm.in_valid = 1'b1;
      tick();
      ifm.in_valid = 1'b0;
      checks++;
      if (ifm.shift_valid !== 1'b0 || ifm.busy !== 1'b1)
         $display("FAIL single_held got valid=%b busy=%b want valid=0 busy=1", ifm.shift_valid, ifm.busy);
      else passed++;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (ifm.shift_valid !== 1'b1 || ifm.shift_out !== exp[7-i] || ifm.frame_start !== (i == 0))
            $display("FAIL single_bit[%0d] got v=%b d=%b f=%b want v=1 d=%b f=%b",
                     i, ifm.shift_valid, ifm.shift_out, ifm.frame_start, exp[7-i], (i == 0));
         else passed++;
      end
      tick();
      checks++;
      if (ifm.shift_valid !== 1'b0 || ifm.shift_out !== 1'b0 || ifm.busy !== 1'b0)
         $display("FAIL single_idle got v=%b d=%b busy=%b want 0 0 0", ifm.shift_valid, ifm.shift_out, ifm.busy);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      exp = 16'hA53C;
      ifm.shift_en = 1'b1;
      ifm.in_data  = 8'hA5;
      ifm.in_valid = 1'b1;
      tick();
      ifm.in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if (ifm.shift_valid !== 1'b1 || ifm.shift_out !== exp[15-i] || ifm.frame_start !== (i == 0 || i == 8))
            $display("FAIL b2b_bit[%0d] got v=%b d=%b f=%b want v=1 d=%b f=%b",
                     i, ifm.shift_valid, ifm.shift_out, ifm.frame_start, exp[15-i], (i == 0 || i == 8));
         else passed++;
         if (i == 5) begin
            checks++;
            if (ifm.in_ready !== 1'b0) $display("FAIL b2b_hold_full_ready got %b want 0", ifm.in_ready);
            else passed++;
         end
         if (i == 8) begin
            checks++;
            if (ifm.in_ready !== 1'b1) $display("FAIL b2b_after_reload_ready got %b want 1", ifm.in_ready);
            else passed++;
         end
         ifm.in_valid = (i == 2);
         ifm.in_data  = 8'h3C;
      end
      ifm.in_valid = 1'b0;
      tick();
      checks++;
      if (ifm.shift_valid !== 1'b0 || ifm.busy !== 1'b0)
         $display("FAIL b2b_idle got v=%b busy=%b want 0 0", ifm.shift_valid, ifm.busy);
      else passed++;
   endtask

   task automatic test_stall();
      logic [7:0] exp;
      exp = 8'hA5;
      ifm.shift_en = 1'b0;
      ifm.in_data  = 8'hA5;
      ifm.in_valid = 1'b1;
      tick();
      ifm.in_valid = 1'b0;
      tick();
      for (int c = 0; c < 16; c++) begin
         tick();
         checks++;
         if (ifm.shift_valid !== 1'b1 || ifm.shift_out !== exp[7-(c/2)] || ifm.frame_start !== (c < 2))
            $display("FAIL stall_cycle[%0d] got v=%b d=%b f=%b want v=1 d=%b f=%b",
                     c, ifm.shift_valid, ifm.shift_out, ifm.frame_start, exp[7-(c/2)], (c < 2));
         else passed++;
         ifm.shift_en = (c % 2 == 1);
      end
      tick();
      checks++;
      if (ifm.shift_valid !== 1'b0 || ifm.busy !== 1'b0)
         $display("FAIL stall_idle got v=%b busy=%b want 0 0", ifm.shift_valid, ifm.busy);
      else passed++;
      ifm.shift_en = 1'b1;
   endtask

   task automatic test_lsb_first();
      logic [7:0] exp;
      exp = 8'h01;
      ifl.shift_en = 1'b1;
      ifl.in_data  = 8'h01;
      ifl.in_valid = 1'b1;
      tick();
      ifl.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (ifl.shift_valid !== 1'b1 || ifl.shift_out !== exp[i] || ifl.frame_start !== (i == 0))
            $display("FAIL lsb_bit[%0d] got v=%b d=%b f=%b want v=1 d=%b f=%b",
                     i, ifl.shift_valid, ifl.shift_out, ifl.frame_start, exp[i], (i == 0));
         else passed++;
      end
      tick();
      checks++;
      if (ifl.shift_valid !== 1'b0) $display("FAIL lsb_idle got %b want 0", ifl.shift_valid);
      else passed++;
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] exp;
      int         seen_valid;
      exp = 8'hA5;
      ifm.shift_en = 1'b1;
      ifm.in_data  = 8'hA5;
      ifm.in_valid = 1'b1;
      tick();
      ifm.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (ifm.shift_out !== exp[7-i]) $display("FAIL midrst_bit[%0d] got %b want %b", i, ifm.shift_out, exp[7-i]);
         else passed++;
         ifm.in_valid = (i == 0);
         ifm.in_data  = 8'h3C;
         if (i == 2) clr = 1'b1;
      end
      tick();
      checks++;
      if (ifm.shift_valid !== 1'b0 || ifm.busy !== 1'b0)
         $display("FAIL midrst_after got v=%b busy=%b want 0 0", ifm.shift_valid, ifm.busy);
      else passed++;
      clr = 1'b0;
      seen_valid = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ifm.shift_valid !== 1'b0) seen_valid++;
      end
      checks++;
      if (seen_valid != 0) $display("FAIL midrst_discard got %0d valid cycles want 0", seen_valid);
      else passed++;
      ifm.in_data  = 8'hFF;
      ifm.in_valid = 1'b1;
      tick();
      ifm.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (ifm.shift_valid !== 1'b1 || ifm.shift_out !== 1'b1 || ifm.frame_start !== (i == 0))
            $display("FAIL midrst_ff_bit[%0d] got v=%b d=%b f=%b want v=1 d=1 f=%b",
                     i, ifm.shift_valid, ifm.shift_out, ifm.frame_start, (i == 0));
         else passed++;
      end
      tick();
      checks++;
      if (ifm.shift_valid !== 1'b0) $display("FAIL midrst_ff_idle got %b want 0", ifm.shift_valid);
      else passed++;
   endtask

   initial begin
      checks       = 0;
      passed       = 0;
      clr          = 1'b1;
      ifm.in_data  = '0;
      ifm.in_valid = 1'b0;
      ifm.shift_en = 1'b0;
      ifl.in_data  = '0;
      ifl.in_valid = 1'b0;
      ifl.shift_en = 1'b0;
      test_reset();
      test_single_msb();
      test_back_to_back();
      test_stall();
      test_lsb_first();
      test_reset_mid_word();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got unfinished run want completion");
      $fatal(1);
   end

endmodule
